// File: rtl/axi_fifo_read_drain.sv
// rtl/axi_fifo_read_drain.sv - FIFO read-side drain into a framed valid/ready stream via a 2-entry skid buffer
module axi_fifo_read_drain #(
  parameter int DATASIZE = 32,
  parameter int LENSIZE  = 11
) (
  input  logic                read_clk,
  input  logic                read_rst,
  input  logic                clear,
  input  logic                empty_read,
  input  logic [DATASIZE-1:0] fifo_rdata,
  output logic                read_enable,
  input  logic                pkt_start,
  input  logic [LENSIZE-1:0]  pkt_len,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy,
  output logic                pkt_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [LENSIZE-1:0] LEN_ZERO = '0;
  localparam logic [LENSIZE-1:0] LEN_ONE  = LENSIZE'(1);

  state_t              r_state;
  logic [LENSIZE-1:0]  r_remaining;
  logic                r_pkt_done;
  logic [1:0]          r_count;
  logic                r_head;
  logic [DATASIZE-1:0] r_data [2];
  logic [1:0]          r_last;

  logic w_accept;
  logic w_pop;
  logic w_tail;
  logic w_pop_last;

  // Head entry of the skid buffer drives the stream; last is qualified by valid.
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data[r_head];
  assign out_last  = out_valid & r_last[r_head];
  assign busy      = (r_state != S_IDLE);
  assign pkt_done  = r_pkt_done;

  assign w_accept = out_valid & out_ready;

  // Pop only while framing, with words still owed and a free slot (or one freeing this cycle).
  assign read_enable = ~clear & (r_state == S_XFER) & ~empty_read &
                       (r_remaining != LEN_ZERO) & ((r_count < 2'd2) | w_accept);
  assign w_pop      = read_enable;
  assign w_pop_last = (r_remaining == LEN_ONE);

  // Write slot follows the occupied entries; when full and draining, the freed head slot is reused.
  assign w_tail = r_head ^ r_count[0];

  // Packet framing FSM: counts words owed and emits the completion pulse.
  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= LEN_ZERO;
      r_pkt_done  <= 1'b0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_remaining <= LEN_ZERO;
      r_pkt_done  <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pkt_start) begin
            if (pkt_len != LEN_ZERO) begin
              r_state     <= S_XFER;
              r_remaining <= pkt_len;
            end else begin
              r_pkt_done <= 1'b1;
            end
          end
        end
        S_XFER: begin
          if (w_pop) begin
            r_remaining <= r_remaining - LEN_ONE;
            if (w_pop_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_accept & out_last) begin
            r_state    <= S_IDLE;
            r_pkt_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Skid buffer occupancy, head pointer and last tags.
  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_last  <= 2'b00;
    end else if (clear) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_last  <= 2'b00;
    end else begin
      if (w_pop) begin
        r_last[w_tail] <= w_pop_last;
      end
      if (w_accept) begin
        r_head <= ~r_head;
      end
      case ({w_pop, w_accept})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Data payload storage; contents are only observed through out_valid, so no reset is needed.
  always_ff @(posedge read_clk) begin
    if (w_pop & ~clear) begin
      r_data[w_tail] <= fifo_rdata;
    end
  end

endmodule

// File: tb/tb_axi_fifo_read_drain.sv
// tb/tb_axi_fifo_read_drain.sv - self-checking bench for axi_fifo_read_drain
module tb_axi_fifo_read_drain;
  localparam int DW   = 32;
  localparam int LW   = 11;
  localparam int NPKT = 200;

  logic          read_clk = 1'b0;
  logic          read_rst = 1'b0;
  logic          clear = 1'b0;
  logic          empty_read = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          read_enable;
  logic          pkt_start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          pkt_done;

  axi_fifo_read_drain #(.DATASIZE(DW), .LENSIZE(LW)) dut (
    .read_clk(read_clk), .read_rst(read_rst), .clear(clear),
    .empty_read(empty_read), .fifo_rdata(fifo_rdata), .read_enable(read_enable),
    .pkt_start(pkt_start), .pkt_len(pkt_len),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .pkt_done(pkt_done)
  );

  always #5 read_clk = ~read_clk;

  typedef struct {
    logic          rdy;
    logic          st;
    logic [LW-1:0] len;
    logic          re;
    logic          vld;
    logic [DW-1:0] dat;
    logic          lst;
    logic          bsy;
    logic          done;
  } vec_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] stream_q[$];
  bit            force_empty = 0;
  bit            sb_en = 0;
  bit            s_re = 0;
  bit            prev_hold = 0;
  bit            done_pending = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int            pkt_left = 0;
  int            n_pops = 0;
  int            n_acc = 0;
  int            n_last = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh_fifo();
    empty_read = (fifo_q.size() == 0) || force_empty;
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // Sample on the falling edge; in scoreboard mode check the stream against the FIFO order.
  task automatic sample();
    bit exp_last;
    @(negedge read_clk);
    s_re = read_enable && !empty_read;
    if (sb_en) begin
      chk("pop_while_empty", read_enable & empty_read, 0);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      chk("pkt_done", pkt_done, done_pending);
      done_pending = 0;
      if (out_valid && out_ready) begin
        n_acc++;
        chk("extra_word", (pkt_left == 0), 0);
        if (stream_q.size() != 0) chk("order", out_data, stream_q.pop_front());
        else chk("order_underrun", stream_q.size(), 1);
        exp_last = (pkt_left == 1);
        chk("last_tag", out_last, exp_last);
        if (out_last) n_last++;
        if (pkt_left > 0) pkt_left--;
        done_pending = exp_last;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  endtask

  // Advance past the rising edge and let the FIFO model react to the pop that happened.
  task automatic tick();
    logic [DW-1:0] w;
    @(posedge read_clk);
    #1;
    if (s_re) begin
      void'(fifo_q.pop_front());
      n_pops++;
    end
    if (sb_en) begin
      while (fifo_q.size() < 3) begin
        w = $urandom;
        fifo_q.push_back(w);
        stream_q.push_back(w);
      end
    end
    refresh_fifo();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    int   ndel;
    int   lastidx;
    bit   got;
    int   pops_before;
    int   launched;
    int   sum_len;
    int   len;
    bit   ok_end;

    // Reset state with a non-empty FIFO (A..D)
    for (int k = 0; k < 4; k++) fifo_q.push_back(32'hA000_0000 + k);
    refresh_fifo();
    @(negedge read_clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_re", read_enable, 0);
    @(posedge read_clk);
    #1;
    read_rst = 1'b1;

    // Test 1: 4-word packet, ready held high
    tv[0] = '{1'b1, 1'b1, 11'd4, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 1'b0, 11'd0, 1'b1, 1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b0, 11'd0, 1'b1, 1'b1, 32'hA000_0001, 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b1, 1'b0, 11'd0, 1'b1, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b0, 11'd0, 1'b0, 1'b1, 32'hA000_0003, 1'b1, 1'b1, 1'b0};
    tv[6] = '{1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    tv[7] = '{1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      out_ready = tv[i].rdy;
      pkt_start = tv[i].st;
      pkt_len   = tv[i].len;
      sample();
      chk($sformatf("t1_re[%0d]", i), read_enable, tv[i].re);
      chk($sformatf("t1_valid[%0d]", i), out_valid, tv[i].vld);
      if (tv[i].vld) chk($sformatf("t1_data[%0d]", i), out_data, tv[i].dat);
      chk($sformatf("t1_last[%0d]", i), out_last, tv[i].lst);
      chk($sformatf("t1_busy[%0d]", i), busy, tv[i].bsy);
      chk($sformatf("t1_done[%0d]", i), pkt_done, tv[i].done);
      tick();
    end
    pkt_start = 1'b0;

    // Test 2: backpressure, len 3, FIFO holds 5 words
    for (int k = 0; k < 5; k++) fifo_q.push_back(32'h2000_0000 + k);
    refresh_fifo();
    out_ready = 1'b0;
    pkt_start = 1'b1;
    pkt_len   = 11'd3;
    sample();
    tick();
    pkt_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk($sformatf("t2_re[%0d]", i), read_enable, (i < 2));
      if (i >= 1) begin
        chk($sformatf("t2_hold_valid[%0d]", i), out_valid, 1);
        chk($sformatf("t2_hold_data[%0d]", i), out_data, 32'h2000_0000);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("t2_valid[%0d]", k), out_valid, 1);
      chk($sformatf("t2_data[%0d]", k), out_data, 32'h2000_0000 + k);
      chk($sformatf("t2_last[%0d]", k), out_last, (k == 2));
      tick();
    end
    sample();
    chk("t2_done", pkt_done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_valid_after", out_valid, 0);
    tick();
    chk("t2_left_in_fifo", fifo_q.size(), 2);
    chk("t2_fifo_head", fifo_q[0], 32'h2000_0003);

    // Test 4: clear with two words buffered and five still owed
    for (int k = 0; k < 8; k++) fifo_q.push_back(32'h4000_0000 + k);
    refresh_fifo();
    out_ready = 1'b0;
    pkt_start = 1'b1;
    pkt_len   = 11'd7;
    sample();
    tick();
    pkt_start = 1'b0;
    sample();
    tick();
    sample();
    tick();
    clear     = 1'b1;
    out_ready = 1'b1;
    sample();
    chk("t4_valid_before_clear", out_valid, 1);
    chk("t4_re_in_clear", read_enable, 0);
    tick();
    clear = 1'b0;
    sample();
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_re", read_enable, 0);
    chk("t4_done0", pkt_done, 0);
    tick();
    sample();
    chk("t4_done1", pkt_done, 0);
    tick();
    pkt_start = 1'b1;
    pkt_len   = 11'd1;
    sample();
    tick();
    pkt_start = 1'b0;
    sample();
    chk("t4_len1_re", read_enable, 1);
    tick();
    sample();
    chk("t4_len1_valid", out_valid, 1);
    chk("t4_len1_data", out_data, 32'h4000_0000);
    chk("t4_len1_last", out_last, 1);
    tick();
    sample();
    chk("t4_len1_done", pkt_done, 1);
    tick();

    // Test 5a: zero-length packet
    pops_before = n_pops;
    pkt_start = 1'b1;
    pkt_len   = 11'd0;
    sample();
    chk("t5_re0", read_enable, 0);
    tick();
    pkt_start = 1'b0;
    sample();
    chk("t5_done", pkt_done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_re1", read_enable, 0);
    tick();
    sample();
    chk("t5_done_once", pkt_done, 0);
    tick();
    chk("t5_no_pops", n_pops, pops_before);

    // Test 5b: pkt_start while busy is ignored
    out_ready = 1'b0;
    pkt_start = 1'b1;
    pkt_len   = 11'd3;
    sample();
    tick();
    pkt_len = 11'd9;
    sample();
    chk("t5b_busy", busy, 1);
    tick();
    pkt_start = 1'b0;
    out_ready = 1'b1;
    ndel = 0;
    lastidx = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      sample();
      if (out_valid && out_ready) begin
        chk($sformatf("t5b_data[%0d]", ndel), out_data, 32'h4000_0001 + ndel);
        ndel++;
        if (out_last) lastidx = ndel;
      end
      if (pkt_done) got = 1;
      tick();
    end
    chk("t5b_done_seen", got, 1);
    chk("t5b_words", ndel, 3);
    chk("t5b_last_idx", lastidx, 3);

    // Test 6: random ready/empty over many packets against the FIFO-order scoreboard
    fifo_q.delete();
    stream_q.delete();
    sb_en = 1;
    prev_hold = 0;
    done_pending = 0;
    pkt_left = 0;
    n_pops = 0;
    n_acc = 0;
    n_last = 0;
    launched = 0;
    sum_len = 0;
    ok_end = 0;
    for (int cyc = 0; cyc < 80000 && !ok_end; cyc++) begin
      out_ready   = ($urandom_range(3) != 0);
      force_empty = ($urandom_range(3) == 0);
      pkt_start   = 1'b0;
      if (!busy && pkt_left == 0 && !done_pending && launched < NPKT) begin
        if (launched == 0) len = 2047;
        else if ($urandom_range(24) == 0) len = $urandom_range(2047, 1000);
        else len = $urandom_range(16, 1);
        pkt_start = 1'b1;
        pkt_len   = LW'(len);
        pkt_left  = len;
        sum_len  += len;
        launched++;
      end else if (busy && $urandom_range(15) == 0) begin
        pkt_start = 1'b1;
        pkt_len   = LW'($urandom);
      end
      refresh_fifo();
      sample();
      tick();
      if (launched == NPKT && pkt_left == 0 && !done_pending && !busy) ok_end = 1;
    end
    pkt_start = 1'b0;
    chk("rand_completed", ok_end, 1);
    chk("rand_pops", n_pops, sum_len);
    chk("rand_accepts", n_acc, sum_len);
    chk("rand_last_count", n_last, NPKT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
